// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the MEM-stage data memory responder.
// The address check lives here so the top and any future checker agree on it.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_BUSY = 2'd1,
    DMR_DONE = 2'd2
  } dmr_state_e;

  localparam logic [31:0] DMR_ERR_DATA = 32'hFFFF_FFFF;

  // Enough for a BUSY countdown of up to 15 cycles.
  localparam int DMR_CNT_W = 4;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmr_req_t;

  // Byte address is unusable if it is not word aligned or falls above the array.
  function automatic logic dmr_addr_bad(input logic [31:0] addr, input int addr_width);
    logic [31:0] high_bits;
    high_bits = addr >> (addr_width + 2);
    return (addr[1:0] != 2'b00) || (high_bits != 32'd0);
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port word array: synchronous write, combinational read of the access
// index, plus an independent combinational debug read port.
module dmr_ram_1rw #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately not reset; the array keeps state across rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata      = mem[addr];
  assign debug_data = mem[debug_addr];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data port responder: latches a pipeline request, waits LATENCY
// BUSY cycles, performs the RAM access, and holds the pipeline via mem_stall.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [31:0]           mem_dout,
  output logic [31:0]           mem_din,
  output logic                  mem_stall,
  output logic                  addr_err,
  input  logic [ADDR_WIDTH-1:0] debug_addr,
  output logic [31:0]           debug_data
);

  dmr_state_e            state;
  dmr_state_e            state_next;
  logic [DMR_CNT_W-1:0]  cnt;
  dmr_req_t              req;

  logic                  req_present;
  logic                  req_err;
  logic                  access;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           ram_rdata;

  assign req_present = mem_ren | mem_wen;
  assign req_err     = (req.ren & req.wen) | dmr_addr_bad(req.addr, ADDR_WIDTH);
  // The access happens on the edge that leaves the last BUSY cycle.
  assign access      = (state == DMR_BUSY) && (cnt == '0);
  assign ram_idx     = req.addr[ADDR_WIDTH+1:2];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DMR_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      DMR_IDLE: if (req_present) state_next = DMR_BUSY;
      DMR_BUSY: if (cnt == '0)   state_next = DMR_DONE;
      DMR_DONE: state_next = DMR_IDLE;
      default:  state_next = DMR_IDLE;
    endcase
  end

  // Outputs: the stall is released only in DONE, when the pipeline may advance.
  always_comb begin
    mem_stall = req_present && (state != DMR_DONE);
    ram_we    = access && req.wen && !req_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if ((state == DMR_IDLE) && req_present) begin
      cnt <= DMR_CNT_W'(LATENCY - 1);
    end else if ((state == DMR_BUSY) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request capture is pure data; an aborted access simply leaves it stale.
  always_ff @(posedge clk) begin
    if ((state == DMR_IDLE) && req_present) begin
      req <= '{ren: mem_ren, wen: mem_wen, addr: mem_addr, wdata: mem_dout};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_din  <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= access && req_err;
      if (access && req.ren) begin
        mem_din <= req_err ? DMR_ERR_DATA : ram_rdata;
      end
    end
  end

  dmr_ram_1rw #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk        (clk),
    .we         (ram_we),
    .addr       (ram_idx),
    .wdata      (req.wdata),
    .rdata      (ram_rdata),
    .debug_addr (debug_addr),
    .debug_data (debug_data)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed and random accesses on a
// LATENCY=2 instance, plus stall-length probes on LATENCY=1 and 15 instances.
module tb_data_mem_responder;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_ren, mem_wen;
  logic [31:0]   mem_addr, mem_dout, mem_din;
  logic          mem_stall, addr_err;
  logic [AW-1:0] debug_addr;
  logic [31:0]   debug_data;

  logic          a_ren, a_wen, a_stall, a_err;
  logic [31:0]   a_addr, a_dout, a_din, a_dbg;
  logic          b_ren, b_wen, b_stall, b_err;
  logic [31:0]   b_addr, b_dout, b_din, b_dbg;
  logic [AW-1:0] probe_daddr;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
    .mem_stall(mem_stall), .addr_err(addr_err),
    .debug_addr(debug_addr), .debug_data(debug_data)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .mem_ren(a_ren), .mem_wen(a_wen),
    .mem_addr(a_addr), .mem_dout(a_dout), .mem_din(a_din),
    .mem_stall(a_stall), .addr_err(a_err),
    .debug_addr(probe_daddr), .debug_data(a_dbg)
  );

  data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(15)) dut_l15 (
    .clk(clk), .rst_n(rst_n), .mem_ren(b_ren), .mem_wen(b_wen),
    .mem_addr(b_addr), .mem_dout(b_dout), .mem_din(b_din),
    .mem_stall(b_stall), .addr_err(b_err),
    .debug_addr(probe_daddr), .debug_data(b_dbg)
  );

  typedef struct {
    bit          chk_din;
    logic [31:0] din;
    logic        err;
    logic [31:0] dbg;
    int          stall;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ram_m [1024];
  logic [31:0] din_m;
  bit          din_known;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word array plus the spec's error and read-return rules.
  task automatic issue(input logic ren, input logic wen, input logic [31:0] addr,
                       input logic [31:0] data);
    exp_t        e;
    logic        err;
    logic [9:0]  idx;
    bit          done;
    idx = addr[11:2];
    err = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0) || (ren && wen);
    if (wen && !err) ram_m[idx] = data;
    if (ren && !wen) begin
      din_m     = err ? 32'hFFFF_FFFF : ram_m[idx];
      din_known = 1'b1;
    end else if (ren && wen) begin
      din_known = 1'b0;
    end
    e.chk_din = din_known;
    e.din     = din_m;
    e.err     = err;
    e.dbg     = ram_m[idx];
    e.stall   = 3;
    mem_ren    = ren;
    mem_wen    = wen;
    mem_addr   = addr;
    mem_dout   = data;
    debug_addr = idx;
    sbq.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("access_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic probe(input int lat, input logic wen, input logic [31:0] data);
    int   n;
    logic st;
    if (lat == 1) begin
      a_ren = !wen; a_wen = wen; a_addr = 32'd0; a_dout = data;
    end else begin
      b_ren = !wen; b_wen = wen; b_addr = 32'd0; b_dout = data;
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      st = (lat == 1) ? a_stall : b_stall;
      if (!st) break;
      n++;
    end
    check($sformatf("stall_len_L%0d", lat), n, lat + 1);
    if (lat == 1) begin
      check("probe_err_L1", {31'd0, a_err}, 32'd0);
      if (wen) check("probe_dbg_L1", a_dbg, data);
      else     check("probe_din_L1", a_din, data);
    end else begin
      check("probe_err_L15", {31'd0, b_err}, 32'd0);
      if (wen) check("probe_dbg_L15", b_dbg, data);
      else     check("probe_din_L15", b_din, data);
    end
    @(posedge clk);
    #1;
    a_ren = 1'b0; a_wen = 1'b0; b_ren = 1'b0; b_wen = 1'b0;
  endtask

  // Monitor: counts stall cycles per access and checks results in DONE.
  initial begin
    int   scnt;
    exp_t e;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        scnt = 0;
      end else if (mem_ren | mem_wen) begin
        if (mem_stall) begin
          scnt++;
          check("addr_err_busy", {31'd0, addr_err}, 32'd0);
        end else begin
          if (sbq.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sbq.pop_front();
            check("stall_len", scnt, e.stall);
            check("addr_err_done", {31'd0, addr_err}, {31'd0, e.err});
            if (e.chk_din) check("mem_din", mem_din, e.din);
            check("debug_data", debug_data, e.dbg);
          end
          scnt = 0;
        end
      end else begin
        check("addr_err_idle", {31'd0, addr_err}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] addr;
    int          kind, op;
    rst_n = 1'b0;
    mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_dout = '0; debug_addr = '0;
    a_ren = 1'b0; a_wen = 1'b0; a_addr = '0; a_dout = '0;
    b_ren = 1'b0; b_wen = 1'b0; b_addr = '0; b_dout = '0;
    probe_daddr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mem_din", mem_din, 32'd0);
    check("reset_addr_err", {31'd0, addr_err}, 32'd0);
    check("reset_stall", {31'd0, mem_stall}, 32'd0);
    rst_n = 1'b1;
    din_m = 32'd0;
    din_known = 1'b1;
    @(posedge clk);
    #1;

    // Give every word of the working pool a known value, back to back.
    for (int i = 0; i < 32; i++) issue(1'b0, 1'b1, i * 4, 32'hA500_0000 + i);
    idle(1);

    issue(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 32'h10, 32'h0);
    idle(1);
    issue(1'b1, 1'b0, 32'h12, 32'h0);
    idle(1);
    issue(1'b0, 1'b1, 32'h1000, 32'h5555_5555);
    idle(1);
    issue(1'b1, 1'b1, 32'h14, 32'h6666_6666);
    idle(1);
    issue(1'b1, 1'b0, 32'h14, 32'h0);
    idle(2);

    // Abort a write to word 8 by resetting in its last BUSY cycle.
    mem_ren = 1'b0; mem_wen = 1'b1; mem_addr = 32'h20; mem_dout = 32'h1234_5678;
    debug_addr = 10'd8;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", {31'd0, mem_stall}, 32'd1);
    check("rst_mid_din", mem_din, 32'd0);
    check("rst_mid_err", {31'd0, addr_err}, 32'd0);
    mem_wen = 1'b0;
    #1;
    check("rst_mid_stall_noreq", {31'd0, mem_stall}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    din_m = 32'd0;
    din_known = 1'b1;
    #1;
    check("rst_abort_word8", debug_data, ram_m[8]);
    @(posedge clk);
    #1;
    issue(1'b0, 1'b1, 32'h24, 32'hC0FF_EE00);
    idle(1);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      addr = $urandom_range(0, 31) * 4;
      if (kind == 0) addr = addr | $urandom_range(1, 3);
      if (kind == 1) addr = addr | (32'h1 << $urandom_range(12, 31));
      op = $urandom_range(0, 8);
      if (op == 0)      issue(1'b1, 1'b1, addr, $urandom);
      else if (op <= 4) issue(1'b1, 1'b0, addr, $urandom);
      else              issue(1'b0, 1'b1, addr, $urandom);
      idle($urandom_range(0, 2));
    end
    idle(2);

    probe(1, 1'b1, 32'h0BAD_F00D);
    probe(1, 1'b0, 32'h0BAD_F00D);
    probe(15, 1'b1, 32'h1357_9BDF);
    probe(15, 1'b0, 32'h1357_9BDF);

    idle(3);
    check("sb_drained", sbq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
